// File: rtl/discrete_filter_pkg.sv
// Shared types and helpers for the discrete-audio filter stages: alpha
// computation, FSM state encoding and 16-bit saturation.
package discrete_filter_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC
    } lpf_state_e;

    // alpha = dt / (RC + dt) in Q16, with dt and RC both scaled by 2^32.
    function automatic logic [63:0] rc_alpha_q16(input logic [63:0] sample_rate,
                                                 input logic [63:0] r,
                                                 input logic [63:0] c_35_shifted);
        logic [63:0] dt32;
        logic [63:0] rc32;
        dt32 = 64'h1_0000_0000 / sample_rate;
        rc32 = (r * c_35_shifted) >> 3;
        return (dt32 << 16) / (rc32 + dt32);
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767) begin
            return 16'sh7fff;
        end else if (v < -18'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/serial_mult_q16.sv
// Serial shift-add multiplier: 17-bit signed multiplicand times a 16-bit
// unsigned constant, one multiplier bit per cycle over 16 cycles.
module serial_mult_q16 #(
    parameter logic [15:0] MULTIPLIER = 16'd612
) (
    input  logic               clk,
    input  logic               I_RST,
    input  logic               start,
    input  logic signed [16:0] multiplicand,
    output logic signed [32:0] product,
    output logic               done
);

    logic [3:0]         cnt_q;
    logic               running_q;
    logic signed [16:0] mcand_q;
    logic signed [32:0] acc_q;
    logic signed [32:0] addend;

    always_comb begin
        addend = {{16{mcand_q[16]}}, mcand_q} << cnt_q;
    end

    always_ff @(posedge clk) begin
        if (I_RST) begin
            cnt_q     <= '0;
            running_q <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
        end else if (start) begin
            cnt_q     <= '0;
            running_q <= 1'b1;
            mcand_q   <= multiplicand;
            acc_q     <= '0;
        end else if (running_q) begin
            if (MULTIPLIER[cnt_q]) begin
                acc_q <= acc_q + addend;
            end
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                running_q <= 1'b0;
            end
        end
    end

    // Flags the last add step; product is final from the following cycle.
    assign done    = running_q && (cnt_q == 4'd15);
    assign product = acc_q;

endmodule

// File: rtl/rc_low_pass_filter_serial.sv
// First-order RC low-pass: out += alpha * (in - out), alpha in Q16, computed
// with a serial multiplier. Define RC_LPF_DITHER_EN to add LFSR dither to diff.
module rc_low_pass_filter_serial
    import discrete_filter_pkg::*;
#(
    parameter int unsigned SAMPLE_RATE  = 48000,
    parameter int unsigned R            = 47000,
    parameter int unsigned C_35_SHIFTED = 1615
) (
    input  logic                       clk,
    input  logic                       I_RST,
    input  logic                       audio_clk_en,
    input  logic signed [SAMPLE_W-1:0] in,
    output logic signed [SAMPLE_W-1:0] out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam logic [63:0] ALPHA64 =
        rc_alpha_q16(64'(SAMPLE_RATE), 64'(R), 64'(C_35_SHIFTED));
    localparam logic [15:0] ALPHA16 = ALPHA64[15:0];

    if (ALPHA64 == 64'd0 || ALPHA64 > 64'd65535) begin : g_alpha_check
        $error("rc_low_pass_filter_serial: ALPHA16 out of range");
    end

    lpf_state_e                 state_q, state_d;
    logic signed [SAMPLE_W-1:0] out_q, out_d;
    logic                       out_valid_q, out_valid_d;
    logic                       overrun_q, overrun_d;
    logic signed [16:0]         diff;
    logic                       mult_start;
    logic                       mult_done;
    logic signed [32:0]         mult_product;

`ifdef RC_LPF_DITHER_EN
    logic [7:0]         lfsr_q;
    logic signed [17:0] diff_wide;

    // x^8 + x^6 + x^5 + x^4 + 1, stepped once per sample strobe.
    always_ff @(posedge clk) begin
        if (I_RST) begin
            lfsr_q <= 8'h01;
        end else if (audio_clk_en) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    // Dither can push diff one step past the 17-bit range, so clamp it.
    always_comb begin
        diff_wide = {{2{in[15]}}, in} - {{2{out_q[15]}}, out_q}
                    + {16'd0, lfsr_q[7:6]} - 18'd2;
        if (diff_wide > 18'sd65535) begin
            diff = 17'sh0ffff;
        end else if (diff_wide < -18'sd65536) begin
            diff = 17'sh10000;
        end else begin
            diff = diff_wide[16:0];
        end
    end
`else
    always_comb begin
        diff = {in[15], in} - {out_q[15], out_q};
    end
`endif

    serial_mult_q16 #(
        .MULTIPLIER(ALPHA16)
    ) u_mult (
        .clk         (clk),
        .I_RST       (I_RST),
        .start       (mult_start),
        .multiplicand(diff),
        .product     (mult_product),
        .done        (mult_done)
    );

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        mult_start  = 1'b0;
        overrun_d   = overrun_q | (audio_clk_en && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (audio_clk_en) begin
                    mult_start = 1'b1;
                    state_d    = MUL;
                end
            end
            MUL: begin
                if (mult_done) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                // Arithmetic shift floors toward -inf.
                out_d = sat16(18'($signed({{2{out_q[15]}}, out_q}) + (mult_product >>> 16)));
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (I_RST) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_rc_low_pass_filter_serial.sv
// Directed bench for rc_low_pass_filter_serial: default instance plus an
// R = 1000 instance for the large-alpha path.
module tb_rc_low_pass_filter_serial;
    import discrete_filter_pkg::*;

    logic               clk;
    logic               rst;
    logic               en_a, en_b;
    logic signed [15:0] in_a, in_b;
    logic signed [15:0] out_a, out_b;
    logic               ov_a, ov_b;
    logic               busy_a, busy_b;
    logic               orun_a, orun_b;

    int tests  = 0;
    int failed = 0;

    rc_low_pass_filter_serial dut_a (
        .clk         (clk),
        .I_RST       (rst),
        .audio_clk_en(en_a),
        .in          (in_a),
        .out         (out_a),
        .out_valid   (ov_a),
        .busy        (busy_a),
        .overrun     (orun_a)
    );

    rc_low_pass_filter_serial #(
        .SAMPLE_RATE (48000),
        .R           (1000),
        .C_35_SHIFTED(1615)
    ) dut_b (
        .clk         (clk),
        .I_RST       (rst),
        .audio_clk_en(en_b),
        .in          (in_b),
        .out         (out_b),
        .out_valid   (ov_b),
        .busy        (busy_b),
        .overrun     (orun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               do_rst;
        logic signed [15:0] x;
        logic signed [15:0] exp_out;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Strobe one sample at the current negedge; lat = negedges until out_valid.
    task automatic run_sample(input bit use_b, input logic signed [15:0] x,
                              output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        if (use_b) begin
            in_b = x;
            en_b = 1'b1;
        end else begin
            in_a = x;
            en_a = 1'b1;
        end
        @(negedge clk);
        en_a = 1'b0;
        en_b = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (use_b ? ov_b : ov_a) begin
                lat = k;
                break;
            end
            if (use_b ? busy_b : busy_a) busy_cnt++;
        end
    endtask

    // First strobe in = 10000, second strobe in = -20000 during cycle second_k.
    task automatic double_strobe(input int second_k, output int pulses);
        pulses = 0;
        in_a   = 16'sd10000;
        en_a   = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            en_a = (k == second_k);
            if (k == second_k) in_a = -16'sd20000;
            if (ov_a) pulses++;
        end
        en_a = 1'b0;
    endtask

    initial begin
        int lat, bcnt, pulses, viol, bad_lat;
        logic signed [15:0] prev;

        // Hand-computed with alpha = 612: out + floor(612 * (in - out) / 65536).
        vecs[0] = '{1'b1,  16'sd10000,  16'sd93};
        vecs[1] = '{1'b1, -16'sd10000, -16'sd94};
        vecs[2] = '{1'b0,  16'sd32767,  16'sd212};
        vecs[3] = '{1'b0, -16'sd32768, -16'sd96};
        vecs[4] = '{1'b0, -16'sd96,    -16'sd96};
        vecs[5] = '{1'b0, -16'sd95,    -16'sd96};
        vecs[6] = '{1'b0, -16'sd97,    -16'sd97};
        vecs[7] = '{1'b1,  16'sd108,    16'sd1};
        vecs[8] = '{1'b0,  16'sd107,    16'sd1};
        vecs[9] = '{1'b1,  16'sd0,      16'sd0};

        rst  = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        in_a = '0;
        in_b = '0;
        @(negedge clk);
        do_reset();

        check("rst_out", out_a, 0);
        check("rst_out_valid", ov_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_overrun", orun_a, 0);

        check("alpha_default", int'(rc_alpha_q16(64'd48000, 64'd47000, 64'd1615)), 612);
        check("alpha_r1000", int'(rc_alpha_q16(64'd48000, 64'd1000, 64'd1615)), 20126);
        check("sat_hi", sat16(18'sd40000), 32767);
        check("sat_lo", sat16(-18'sd40000), -32768);
        check("sat_edge_hi", sat16(18'sd32767), 32767);
        check("sat_edge_lo", sat16(-18'sd32768), -32768);
        check("sat_pass", sat16(-18'sd5), -5);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_rst) do_reset();
            run_sample(1'b0, vecs[i].x, lat, bcnt);
            check($sformatf("vec%0d_latency", i), lat, 18);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, 17);
            check($sformatf("vec%0d_out", i), out_a, vecs[i].exp_out);
            @(negedge clk);
            check($sformatf("vec%0d_valid_one_cycle", i), ov_a, 0);
        end

        // Second strobe mid-MUL, during ACC, and just after ACC.
        do_reset();
        double_strobe(5, pulses);
        check("ovr_mul_pulses", pulses, 1);
        check("ovr_mul_out", out_a, 93);
        check("ovr_mul_flag", orun_a, 1);

        do_reset();
        double_strobe(17, pulses);
        check("ovr_acc_pulses", pulses, 1);
        check("ovr_acc_out", out_a, 93);
        check("ovr_acc_flag", orun_a, 1);

        do_reset();
        double_strobe(18, pulses);
        check("idle_strobe_pulses", pulses, 2);
        check("idle_strobe_out", out_a, -95);
        check("idle_strobe_flag", orun_a, 0);

        // Reset during cycle 8 of MUL, after an overrun has been flagged.
        do_reset();
        in_a = 16'sd10000;
        en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
        en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_rst_pre_overrun", orun_a, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out", out_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_overrun", orun_a, 0);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            if (ov_a) pulses++;
            @(negedge clk);
        end
        check("mid_rst_no_valid", pulses, 0);
        run_sample(1'b0, 16'sd10000, lat, bcnt);
        check("mid_rst_next_latency", lat, 18);
        check("mid_rst_next_out", out_a, 93);

        // Convergence toward 10000; the floor stalls it once 612 * diff < 65536.
        do_reset();
        viol    = 0;
        bad_lat = 0;
        prev    = out_a;
        for (int n = 0; n < 800; n++) begin
            run_sample(1'b0, 16'sd10000, lat, bcnt);
            if (lat != 18) bad_lat++;
            if (out_a < prev) viol++;
            prev = out_a;
        end
        check("conv_latency", bad_lat, 0);
        check("conv_monotonic", viol, 0);
        check("conv_band", int'(out_a >= 16'sd9893 && out_a <= 16'sd10000), 1);

        // R = 1000 gives alpha = 20126: drive to full scale negative, then step up.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            run_sample(1'b1, -16'sd32768, lat, bcnt);
        end
        check("r1k_neg_rail", out_b, -32768);
        run_sample(1'b1, 16'sd32767, lat, bcnt);
        check("r1k_step_latency", lat, 18);
        check("r1k_step_out", out_b, -12643);
        run_sample(1'b1, 16'sd32767, lat, bcnt);
        check("r1k_second_out", out_b, 1302);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
